ucsbece154b_prefetch: RTL
=========================

// Module: ucsbece154b_prefetch
// PURPOSE
//  Next-line instruction prefetcher between the icache miss port and the SDRAM controller.
//  Forwards icache demand misses to SDRAM and returns words critical-word-first.
//  After each demand, fetches the next sequential block into a one-block stream buffer.
//  Later misses that hit the buffer are served from it with no SDRAM access.
// PARAMETERS
//  BLOCK_WORDS      4   words per cache block (power of 2, >=2)
//  WORD_SIZE        32  bits per word
//  PREFETCH_ENABLE  1   0: pure pass-through, buffer never filled
// PORTS
//  clk                 in   1   single clock
//  reset               in   1   synchronous, active-high
//  memReadRequest      in   1   icache miss request (held until memDataReady seen)
//  memReadAddress      in   32  icache miss byte address
//  memDataIn           out  32  word to icache
//  memDataReady        out  1   high for exactly BLOCK_WORDS consecutive cycles per block
//  memBlockIndex       out  LBW word index within block of memDataIn (LBW=$clog2(BLOCK_WORDS))
//  sdramReadRequest    out  1   held until sdramDataReady first seen
//  sdramReadAddress    out  32  byte address; returned burst starts at word [LBW+1:2], wraps
//  sdramDataIn         in   32  burst word
//  sdramDataReady      in   1   high for BLOCK_WORDS consecutive cycles, one word per cycle
// BEHAVIOUR
//  Reset: state IDLE, buffer invalid, all outputs 0, sdramReadAddress 0.
//    Reset mid-burst aborts everything; SDRAM controller is reset on the same edge.
//  blk(a) = a[31:LBW+2]; crit = a[LBW+1:2]. Word k of a transfer has index (crit+k) mod BLOCK_WORDS.
//  States: IDLE, DEM_REQ, DEM_XFER, BUF_XFER, PF_REQ, PF_XFER.
//  IDLE, on memReadRequest:
//    If buffer valid and blk==bufTag: latch addr -> BUF_XFER.
//    Else: latch addr -> DEM_REQ.
//    Only one request is launched per idle period.
//  DEM_REQ: sdramReadRequest=1, sdramReadAddress=latched addr. -> DEM_XFER on sdramDataReady.
//    The same cycle also forwards word 0.
//  DEM_XFER: combinational forward, zero added latency.
//    memDataIn=sdramDataIn, memDataReady=sdramDataReady, memBlockIndex=crit+count.
//    On the last word: buffer invalidated. -> PF_REQ if PREFETCH_ENABLE, else IDLE.
//  BUF_XFER: starts the cycle after acceptance. Runs BLOCK_WORDS cycles.
//    memDataIn=buf[crit+count] (registered). After the last word, the buffer is invalidated.
//    -> PF_REQ if PREFETCH_ENABLE for blk+1, else IDLE.
//  PF_REQ: sdramReadRequest=1, addr={blk+1, (LBW+2)'b0}. Block number wraps mod 2^(30-LBW).
//    -> PF_XFER on sdramDataReady.
//  PF_XFER: words written to buf[count], never forwarded. On the last word: bufTag=blk+1, valid=1 -> IDLE.
//  memReadRequest during PF_REQ/PF_XFER is not accepted. It waits until IDLE, then is evaluated.
//    If it matches the new buffer, it is a buffer hit.
//  Dropped request: once accepted, a transfer completes even if memReadRequest falls.
//    This happens when the icache hits in its delay state. memDataReady pulses are then ignored by icache.
//  Requests arriving in DEM_*/BUF_XFER are ignored. The icache cannot issue them (it is in words/write).
//  count: LBW-bit counter, cleared on entering any XFER. Increments each cycle sdramDataReady or BUF_XFER holds.
//  memDataReady is never high outside DEM_XFER/BUF_XFER.
//  sdramReadRequest is never high in IDLE/XFER states.
// STRUCTURE
//  Package ucsbece154b_mem_pkg: LBW/WORD_SIZE constants, pf_state_t enum, blk/crit helper functions.
//  Sub-module ucsbece154b_stream_buffer: BLOCK_WORDS x WORD_SIZE regs, tag, valid.
//    Write port (idx, data), invalidate, read idx, match output.
//  Top: FSM, counter, address latch, output muxes.
// TESTING
//  Cold miss 0x104 with SDRAM delay 5:
//    -> sdramReadAddress=0x104.
//    -> memDataReady for 4 cycles, indices 1,2,3,0.
//    -> then PF_REQ at addr 0x110, buffer tag for 0x110.
//  Miss 0x118 after the above:
//    -> no sdramReadRequest.
//    -> memDataReady starts the next cycle, indices 2,3,0,1, data from buffer.
//    -> then prefetch at 0x120.
//  Miss 0x200 arriving during PF_XFER:
//    -> held until prefetch completes.
//    -> then demand 0x200, buffer invalidated.
//  memReadRequest dropped 1 cycle after acceptance:
//    -> demand burst still completes, 4 pulses, then prefetch.
//  Miss 0xFFFFFFF0:
//    -> prefetch address 0x00000000.
//  Reset asserted mid DEM_XFER:
//    -> next cycle all outputs 0, IDLE.
//    -> next miss to a former buffer block goes to SDRAM.
//  PREFETCH_ENABLE=0:
//    -> exactly one sdramReadRequest per miss, never BUF_XFER.

Source files
------------

// File: rtl/ucsbece154b_mem_pkg.sv
// Shared constants, FSM state type and block/critical-word helpers for the
// next-line instruction prefetcher.
package ucsbece154b_mem_pkg;

    localparam int DEF_WORD_SIZE   = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_LBW         = $clog2(DEF_BLOCK_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEM_REQ,
        ST_DEM_XFER,
        ST_BUF_XFER,
        ST_PF_REQ,
        ST_PF_XFER
    } pf_state_t;

    // Block number of a byte address (caller truncates to its tag width).
    function automatic logic [31:0] blk_of(input logic [31:0] a, input int lbw);
        return a >> (lbw + 2);
    endfunction

    // Word index within the block of a byte address.
    function automatic logic [31:0] crit_of(input logic [31:0] a, input int lbw);
        return (a >> 2) & ((32'd1 << lbw) - 32'd1);
    endfunction

endpackage

// File: rtl/ucsbece154b_stream_buffer.sv
// One-block stream buffer: word storage, block tag and valid bit with a
// combinational read port and tag match.
module ucsbece154b_stream_buffer #(
    parameter int  BLOCK_WORDS = 4,
    parameter int  WORD_SIZE   = 32,
    localparam int LBW         = $clog2(BLOCK_WORDS),
    localparam int TAG_W       = 30 - LBW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic [LBW-1:0]       wr_idx_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic                 fill_done_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic                 inval_i,
    input  logic [LBW-1:0]       rd_idx_i,
    output logic [WORD_SIZE-1:0] rd_data_o,
    input  logic [TAG_W-1:0]     lookup_tag_i,
    output logic                 match_o
);

    logic [WORD_SIZE-1:0] mem_q [BLOCK_WORDS];
    logic [TAG_W-1:0]     tag_q;
    logic                 valid_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // The last fill word and the tag update land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (fill_done_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign match_o   = valid_q && (tag_q == lookup_tag_i);

endmodule

// File: rtl/ucsbece154b_prefetch.sv
// Next-line instruction prefetcher: forwards icache misses to SDRAM
// critical-word-first and prefetches the following block into a stream buffer.
module ucsbece154b_prefetch import ucsbece154b_mem_pkg::*; #(
    parameter int BLOCK_WORDS     = DEF_BLOCK_WORDS,
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter bit PREFETCH_ENABLE = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           memReadRequest,
    input  logic [31:0]                    memReadAddress,
    output logic [WORD_SIZE-1:0]           memDataIn,
    output logic                           memDataReady,
    output logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
    output logic                           sdramReadRequest,
    output logic [31:0]                    sdramReadAddress,
    input  logic [WORD_SIZE-1:0]           sdramDataIn,
    input  logic                           sdramDataReady
);

    localparam int LBW   = $clog2(BLOCK_WORDS);
    localparam int TAG_W = 30 - LBW;

    pf_state_t      state_q;
    logic [31:0]    addr_q;
    logic [LBW-1:0] cnt_q;
    logic           req_q;
    logic [31:0]    sdaddr_q;

    logic [TAG_W-1:0]     cur_tag, next_tag, lookup_tag;
    logic [LBW-1:0]       crit;
    logic                 last, buf_match, buf_wr, buf_fill, buf_inval;
    logic [WORD_SIZE-1:0] buf_rd;
    logic [31:0]          pf_addr;

    assign cur_tag    = TAG_W'(blk_of(addr_q, LBW));
    assign next_tag   = cur_tag + TAG_W'(1);
    assign lookup_tag = TAG_W'(blk_of(memReadAddress, LBW));
    assign crit       = LBW'(crit_of(addr_q, LBW));
    assign pf_addr    = {next_tag, {(LBW + 2){1'b0}}};
    assign last       = (cnt_q == LBW'(BLOCK_WORDS - 1));

    // Prefetch words arrive in block order starting at word 0.
    assign buf_wr    = sdramDataReady && (state_q == ST_PF_REQ || state_q == ST_PF_XFER);
    assign buf_fill  = sdramDataReady && (state_q == ST_PF_XFER) && last;
    assign buf_inval = last && ((state_q == ST_BUF_XFER) ||
                                (state_q == ST_DEM_XFER && sdramDataReady));

    ucsbece154b_stream_buffer #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .WORD_SIZE   (WORD_SIZE)
    ) u_sbuf (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (buf_wr),
        .wr_idx_i     (cnt_q),
        .wr_data_i    (sdramDataIn),
        .fill_done_i  (buf_fill),
        .fill_tag_i   (next_tag),
        .inval_i      (buf_inval),
        .rd_idx_i     (crit + cnt_q),
        .rd_data_o    (buf_rd),
        .lookup_tag_i (lookup_tag),
        .match_o      (buf_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            sdaddr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memReadRequest) begin
                        addr_q <= memReadAddress;
                        cnt_q  <= '0;
                        if (buf_match) begin
                            state_q <= ST_BUF_XFER;
                        end else begin
                            state_q  <= ST_DEM_REQ;
                            req_q    <= 1'b1;
                            sdaddr_q <= memReadAddress;
                        end
                    end
                end
                // The first burst word arrives while still in a REQ state.
                ST_DEM_REQ, ST_PF_REQ: begin
                    if (sdramDataReady) begin
                        req_q   <= 1'b0;
                        cnt_q   <= cnt_q + LBW'(1);
                        state_q <= (state_q == ST_DEM_REQ) ? ST_DEM_XFER : ST_PF_XFER;
                    end
                end
                ST_DEM_XFER, ST_BUF_XFER: begin
                    if (sdramDataReady || state_q == ST_BUF_XFER) begin
                        cnt_q <= cnt_q + LBW'(1);
                        if (last) begin
                            if (PREFETCH_ENABLE) begin
                                state_q  <= ST_PF_REQ;
                                req_q    <= 1'b1;
                                sdaddr_q <= pf_addr;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_PF_XFER: begin
                    if (sdramDataReady) begin
                        cnt_q <= cnt_q + LBW'(1);
                        if (last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        memDataReady  = 1'b0;
        memDataIn     = '0;
        memBlockIndex = '0;
        if ((state_q == ST_DEM_REQ || state_q == ST_DEM_XFER) && sdramDataReady) begin
            memDataReady  = 1'b1;
            memDataIn     = sdramDataIn;
            memBlockIndex = crit + cnt_q;
        end else if (state_q == ST_BUF_XFER) begin
            memDataReady  = 1'b1;
            memDataIn     = buf_rd;
            memBlockIndex = crit + cnt_q;
        end
    end

    assign sdramReadRequest = req_q;
    assign sdramReadAddress = sdaddr_q;

endmodule
